// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family.
//   ptr_w(d) : pointer width for a depth-d FIFO ($clog2(d))
//   cnt_w(d) : occupancy counter width, able to hold 0..d ($clog2(d)+1)
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int ptr_w(input int d);
    return $clog2(d);
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// W x D simple dual-port storage array.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : word at raddr
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ptr_w(D)-1:0]   waddr,
  input  logic [W-1:0]          wdata,
  input  logic [ptr_w(D)-1:0]   raddr,
  output logic [W-1:0]          rdata
);

  logic [W-1:0] mem [D];

  // NOTE: storage is deliberately not reset; the FIFO never exposes a word
  // before it has been written, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable watermarks,
// synchronous flush, sticky error flags and selectable FWFT read mode.
//   clk          : sole clock, rising edge
//   rst_n        : synchronous active-low reset
//   flush        : synchronous clear of contents and error flags
//   w_en / d_in  : write request and data
//   r_en         : read request (pop in FWFT mode)
//   d_out        : read data
//   full / empty : count==D / count==0
//   almost_full  : count >= AF_TH
//   almost_empty : count <= AE_TH
//   count        : occupancy 0..D
//   overflow     : sticky, set by a write while full
//   underflow    : sticky, set by a read while empty
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int W     = 8,
  parameter int D     = 32,
  parameter int AF_TH = D - 4,
  parameter int AE_TH = 4,
  parameter int FWFT  = FIFO_STD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 w_en,
  input  logic [W-1:0]         d_in,
  input  logic                 r_en,
  output logic [W-1:0]         d_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [cnt_w(D)-1:0]  count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int PTR_W = ptr_w(D);
  localparam int CNT_W = cnt_w(D);

  // Reject illegal configurations at elaboration time.
  if ((W < 1) || (D < 2) || ((D & (D - 1)) != 0) ||
      (AF_TH < 1) || (AF_TH > D) ||
      (AE_TH < 0) || (AE_TH > D - 1) ||
      ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT))) begin : g_bad_param
    $error("sync_fifo_flags: illegal parameter combination");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     rd_data;
  logic             wr_acc;
  logic             rd_acc;
  logic             mem_we;

  // Flags decode from the count register only, never from the inputs.
  assign full         = (count_q == CNT_W'(D));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_TH));
  assign almost_empty = (count_q <= CNT_W'(AE_TH));
  assign count        = count_q;

  // No pass-through: a full FIFO refuses writes and an empty one refuses
  // reads even when the opposite port is active in the same cycle.
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  // Writes presented during reset or flush must not land in storage.
  assign mem_we = wr_acc && rst_n && !flush;

  fifo_mem #(
    .W (W),
    .D (D)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (d_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // NOTE: all state registers use non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (w_en && full) begin
        overflow <= 1'b1;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  if (FWFT == FIFO_STD) begin : g_std
    // Registered read: the popped word appears one edge after r_en and is
    // held until the next accepted read. Flush leaves it untouched.
    logic [W-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (!flush && rd_acc) begin
        dout_q <= rd_data;
      end
    end

    assign d_out = dout_q;
  end else begin : g_fwft
    // Head word is shown directly; forced to zero while empty so reset and
    // flush present a clean value.
    assign d_out = empty ? '0 : rd_data;
  end

endmodule
